ula_arbiter: RTL and testbench



---
 rtl/ula_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ula_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// ---------------------------------------------------------------------------
// ula_arbiter
//
// Round-robin scheduler that shares one combinational `ula` between two
// requesters. A request (opcode + A/B operands) is accepted over a
// valid/ready handshake, latched, presented to the `ula` for one cycle,
// and the registered result is returned on the granted port's response
// channel with its own valid/ready handshake.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake, port N in {0,1}
//   reqN_op, reqN_a, reqN_b    request opcode and operands
//   respN_valid / respN_ready  response handshake, port N in {0,1}
//   resp_data                  registered result shared by both ports
//   resp_zero, resp_neg        result flags (only with ULA_ARB_FLAGS_EN)
//   alu_a, alu_b, alu_s        drive the shared `ula` inputs a, b, s
//   alu_out                    result from the shared `ula`
//
// Configuration macro:
//   ULA_ARB_FLAGS_EN  adds the registered resp_zero / resp_neg outputs.
// ---------------------------------------------------------------------------
module ula_arbiter #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
`ifdef ULA_ARB_FLAGS_EN
  output logic             resp_zero,
  output logic             resp_neg,
`endif
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_s,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Port granted most recently; a tie goes to the other port.
  logic last_grant;
  // Port that owns the operation currently in EXEC/RESP.
  logic gnt_q;

  logic win0, win1;
  logic accept;

  // Round-robin winner selection, only consulted while IDLE.
  assign win0 = req0_valid & (~req1_valid | last_grant);
  assign win1 = req1_valid & (~req0_valid | ~last_grant);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = win0;
        req1_ready = win1;
        if (win0 || win1) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        resp0_valid = ~gnt_q;
        resp1_valid = gnt_q;
        if (gnt_q ? resp1_ready : resp0_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept = req0_ready | req1_ready;

  // Latched request (drives the ula directly) and grant bookkeeping.
  // The alu_* outputs are the latch registers, so they hold their last
  // value while IDLE and are stable throughout EXEC and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_s      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      gnt_q      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      alu_s      <= req1_ready ? req1_op : req0_op;
      alu_a      <= req1_ready ? req1_a  : req0_a;
      alu_b      <= req1_ready ? req1_b  : req0_b;
      gnt_q      <= req1_ready;
      last_grant <= req1_ready;
    end
  end

  // Result capture at the end of EXEC; held unchanged through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data <= '0;
    end else if (state == EXEC) begin
      resp_data <= alu_out;
    end
  end

`ifdef ULA_ARB_FLAGS_EN
  // Flags are captured on the same edge as resp_data so they always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_zero <= 1'b0;
      resp_neg  <= 1'b0;
    end else if (state == EXEC) begin
      resp_zero <= (alu_out == '0);
      resp_neg  <= alu_out[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ula_arbiter
//
// Self-checking bench for ula_arbiter. A small behavioural ula closes the
// loop on alu_* / alu_out. Directed stimulus pushes the hand-computed
// expected response (port, data) into a queue at acceptance; a monitor on
// the falling edge pops and compares on every response handshake.
// Honours ULA_ARB_FLAGS_EN for the optional flag outputs.
// ---------------------------------------------------------------------------
module tb_ula_arbiter;

  localparam int WIDTH = 8;
  localparam int OP_W  = 4;

  typedef struct {
    bit             port;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [OP_W-1:0]  req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             resp0_valid, resp1_valid;
  logic             resp0_ready, resp1_ready;
  logic [WIDTH-1:0] resp_data;
`ifdef ULA_ARB_FLAGS_EN
  logic             resp_zero, resp_neg;
`endif
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [OP_W-1:0]  alu_s;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  ula_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp0_valid(resp0_valid),
    .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid),
    .resp1_ready(resp1_ready),
    .resp_data  (resp_data),
`ifdef ULA_ARB_FLAGS_EN
    .resp_zero  (resp_zero),
    .resp_neg   (resp_neg),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_out    (alu_out)
  );

  // Behavioural stand-in for the combinational ula.
  always_comb begin
    alu_out = '0;
    case (alu_s)
      4'd0: alu_out = alu_a + alu_b;
      4'd1: alu_out = alu_a - alu_b;
      4'd2: alu_out = alu_a & alu_b;
      4'd3: alu_out = alu_a | alu_b;
      4'd4: alu_out = ~alu_a;
      default: alu_out = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compare on every response handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (resp0_valid && resp1_valid) begin
        check("both_resp_valid", 32'd1, 32'd0);
      end
      if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_port", {31'd0, resp1_valid}, {31'd0, e.port});
          check("resp_data", {24'd0, resp_data}, {24'd0, e.data});
`ifdef ULA_ARB_FLAGS_EN
          check("resp_zero", {31'd0, resp_zero}, {31'd0, e.data == '0});
          check("resp_neg",  {31'd0, resp_neg},  {31'd0, e.data[WIDTH-1]});
`endif
        end
      end
    end
  end

  task automatic set_req(input bit port, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (port) begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
  endtask

  // Issue one request and wait (bounded) for acceptance. Called just after
  // a rising edge; returns 1 time unit after the accepting edge.
  task automatic issue(input bit port, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_data, input bit push,
                       output int waited);
    bit got;
    exp_t e;
    got    = 1'b0;
    waited = 0;
    set_req(port, op, a, b);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) got = 1'b1;
      else waited++;
    end
    check("accept_timeout", {31'd0, got}, 32'd1);
    if (got && push) begin
      e.port = port;
      e.data = exp_data;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_timeout", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {30'd0, req0_ready, req1_ready}, 32'd0);
    check({tag, "_resp_valid"}, {30'd0, resp0_valid, resp1_valid}, 32'd0);
    check({tag, "_resp_data"}, {24'd0, resp_data}, 32'd0);
    check({tag, "_alu"}, {4'd0, alu_s, alu_a, alu_b}, 32'd0);
`ifdef ULA_ARB_FLAGS_EN
    check({tag, "_flags"}, {30'd0, resp_zero, resp_neg}, 32'd0);
`endif
  endtask

  initial begin
    int w;
    exp_t e;
    bit first_port;

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add on port 0: ready in the request cycle, response 2 cycles on.
    issue(1'b0, 4'd0, 8'h12, 8'h34, 8'h46, 1'b1, w);
    check("add_same_cycle_ready", w, 0);
    @(negedge clk);
    check("add_exec_no_valid", {31'd0, resp0_valid}, 32'd0);
    check("add_exec_alu", {4'd0, alu_s, alu_a, alu_b}, 32'h0001234);
    @(negedge clk);
    check("add_resp0_valid", {31'd0, resp0_valid}, 32'd1);
    check("add_resp1_low", {31'd0, resp1_valid}, 32'd0);
    check("add_no_ready_in_resp", {30'd0, req0_ready, req1_ready}, 32'd0);
    wait_drain();

    // Subtract with wrap on port 1.
    issue(1'b1, 4'd1, 8'h00, 8'h01, 8'hFF, 1'b1, w);
    wait_drain();

    // Contention: both ports held valid; grants must alternate 0,1,0,1.
    set_req(1'b0, 4'd2, 8'hF0, 8'h3C);
    set_req(1'b1, 4'd3, 8'hF0, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) got = 1'b1;
      end
      check("contend_timeout", {31'd0, got}, 32'd1);
      check("contend_single_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
      first_port = (i % 2 == 1);
      check("contend_grant_order", {31'd0, req1_ready}, {31'd0, first_port});
      e.port = first_port;
      e.data = first_port ? 8'hFF : 8'h30;
      sb_q.push_back(e);
      @(posedge clk); #1;
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    wait_drain();

    // Backpressure: port 0 NOT A held in RESP; port 1 waits meanwhile.
    resp0_ready = 1'b0;
    issue(1'b0, 4'd4, 8'h5A, 8'h00, 8'hA5, 1'b1, w);
    @(posedge clk); #1;               // now in RESP
    set_req(1'b1, 4'd0, 8'h01, 8'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", {31'd0, resp0_valid}, 32'd1);
      check("bp_data_stable", {24'd0, resp_data}, 32'hA5);
      check("bp_req1_blocked", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1;
    end
    resp0_ready = 1'b1;
    @(negedge clk);                   // response handshake cycle
    check("bp_req1_blocked_hs", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);                   // first IDLE cycle after handshake
    check("bp_req1_accept_next", {31'd0, req1_ready}, 32'd1);
    e.port = 1'b1;
    e.data = 8'h02;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_drain();

    // Invalid opcode yields zero.
    issue(1'b0, 4'd9, 8'hFF, 8'hFF, 8'h00, 1'b1, w);
    wait_drain();

    // Reset during EXEC: request dropped, outputs cleared without a clock.
    issue(1'b0, 4'd0, 8'h01, 8'h01, 8'h00, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midreset_no_resp", {30'd0, resp0_valid, resp1_valid}, 32'd0);
    end
    // Last grant before reset was port 0; reset restores port 0 priority.
    @(posedge clk); #1;
    set_req(1'b0, 4'd3, 8'h0F, 8'hF0);
    set_req(1'b1, 4'd2, 8'h0F, 8'hF0);
    @(negedge clk);
    check("midreset_tie_port0", {30'd0, req0_ready, req1_ready}, 32'd2);
    if (req0_ready) begin
      e.port = 1'b0;
      e.data = 8'hFF;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
